regs_rename_ckpt: RTL and testbench

//  Parametrised architectural register file with rename status (busy bit + ROB tag per register).

---
 rtl/regs_rename_ckpt_if.sv | 41 ++++
 rtl/regs_rename_ckpt.sv | 135 +++++++++++++
 tb/tb_regs_rename_ckpt.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/regs_rename_ckpt_if.sv
// Rename register-file bundle: read, allocate, writeback and checkpoint signals.
// The master drives requests; the slave returns read data and checkpoint status.
interface regs_rename_ckpt_if #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 6,
    parameter int NREAD  = 8,
    parameter int NALLOC = 4,
    parameter int NWB    = 3
);
    localparam int AW = $clog2(NREGS);
    localparam int RW = DATA_W + 1 + TAG_W;

    logic                     flush;
    logic [NREAD*AW-1:0]      raddr;
    logic [NREAD*RW-1:0]      rdata;
    logic [NALLOC-1:0]        alloc_en;
    logic [NALLOC*AW-1:0]     alloc_addr;
    logic [NALLOC*TAG_W-1:0]  alloc_tag;
    logic [NWB-1:0]           wb_en;
    logic [NWB*AW-1:0]        wb_addr;
    logic [NWB*DATA_W-1:0]    wb_data;
    logic [NWB*TAG_W-1:0]     wb_tag;
    logic                     ckpt_save;
    logic                     ckpt_restore;
    logic                     ckpt_valid;

    modport master (
        output flush, raddr, alloc_en, alloc_addr, alloc_tag,
        output wb_en, wb_addr, wb_data, wb_tag,
        output ckpt_save, ckpt_restore,
        input  rdata, ckpt_valid
    );

    modport slave (
        input  flush, raddr, alloc_en, alloc_addr, alloc_tag,
        input  wb_en, wb_addr, wb_data, wb_tag,
        input  ckpt_save, ckpt_restore,
        output rdata, ckpt_valid
    );
endinterface

// File: rtl/regs_rename_ckpt.sv
// Architectural register file with per-register busy/ROB-tag rename status
// and a one-deep busy/tag checkpoint for branch recovery.
module regs_rename_ckpt #(
    parameter int NREGS    = 8,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 6,
    parameter int NREAD    = 8,
    parameter int NALLOC   = 4,
    parameter int NWB      = 3,
    parameter int ZERO_REG = 0
) (
    input  logic clk,
    input  logic rst_n,
    regs_rename_ckpt_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int RW = DATA_W + 1 + TAG_W;

    logic [DATA_W-1:0] data_q [NREGS];
    logic [DATA_W-1:0] data_d [NREGS];
    logic [TAG_W-1:0]  tag_q  [NREGS];
    logic [TAG_W-1:0]  tag_d  [NREGS];
    logic [TAG_W-1:0]  stag_q [NREGS];
    logic [TAG_W-1:0]  stag_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [NREGS-1:0]  sbusy_q, sbusy_d;
    logic              cv_q, cv_d;
    logic [NREAD*AW-1:0] raddr_q;
    logic              rst_act;

    assign rst_act = bus.ckpt_restore & cv_q;

    always_comb begin
        logic             a_hit;
        logic [TAG_W-1:0] a_tag;
        logic             c_live;
        logic             c_snap;
        for (int r = 0; r < NREGS; r++) begin
            data_d[r]  = data_q[r];
            tag_d[r]   = tag_q[r];
            busy_d[r]  = busy_q[r];
            a_hit      = 1'b0;
            a_tag      = tag_q[r];
            c_live     = 1'b0;
            c_snap     = 1'b0;
            // Ascending lane order: the highest lane's write lands last.
            for (int k = 0; k < NWB; k++) begin
                if (bus.wb_en[k] && bus.wb_addr[k*AW +: AW] == AW'(r)) begin
                    data_d[r] = bus.wb_data[k*DATA_W +: DATA_W];
                    if (bus.wb_tag[k*TAG_W +: TAG_W] == tag_q[r])
                        c_live = 1'b1;
                    if (bus.wb_tag[k*TAG_W +: TAG_W] == stag_q[r])
                        c_snap = 1'b1;
                end
            end
            for (int j = 0; j < NALLOC; j++) begin
                if (bus.alloc_en[j] && bus.alloc_addr[j*AW +: AW] == AW'(r)) begin
                    a_hit = 1'b1;
                    a_tag = bus.alloc_tag[j*TAG_W +: TAG_W];
                end
            end
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end else if (rst_act) begin
                tag_d[r]  = stag_q[r];
                busy_d[r] = sbusy_q[r] & ~c_snap;
            end else if (a_hit) begin
                tag_d[r]  = a_tag;
                busy_d[r] = 1'b1;
            end else if (c_live) begin
                busy_d[r] = 1'b0;
            end
            if (bus.ckpt_save) begin
                stag_d[r]  = tag_d[r];
                sbusy_d[r] = busy_d[r];
            end else begin
                stag_d[r]  = stag_q[r];
                sbusy_d[r] = sbusy_q[r] & ~c_snap;
            end
            if (ZERO_REG != 0 && r == 0) begin
                data_d[r]  = '0;
                tag_d[r]   = '0;
                busy_d[r]  = 1'b0;
                stag_d[r]  = '0;
                sbusy_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        cv_d = cv_q;
        if (bus.flush)
            cv_d = 1'b0;
        else if (bus.ckpt_save)
            cv_d = 1'b1;
        else if (rst_act)
            cv_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
                stag_q[r] <= '0;
            end
            busy_q  <= '0;
            sbusy_q <= '0;
            cv_q    <= 1'b0;
            raddr_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
                stag_q[r] <= stag_d[r];
            end
            busy_q  <= busy_d;
            sbusy_q <= sbusy_d;
            cv_q    <= cv_d;
            raddr_q <= bus.raddr;
        end
    end

    // Read from post-edge state so a read sees same-edge updates.
    always_comb begin
        logic [AW-1:0] a;
        bus.rdata = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = raddr_q[i*AW +: AW];
            bus.rdata[i*RW +: RW] = {data_q[a], busy_q[a], tag_q[a]};
        end
    end

    assign bus.ckpt_valid = cv_q;
endmodule

// File: tb/tb_regs_rename_ckpt.sv
// Scoreboard bench for regs_rename_ckpt: default build plus a
// ZERO_REG=1, NREGS=16, NREAD=2 build sharing one clock.
module tb_regs_rename_ckpt;
    localparam int RW = 23;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regs_rename_ckpt_if #(.NREGS(8), .DATA_W(16), .TAG_W(6),
        .NREAD(8), .NALLOC(4), .NWB(3)) if0 ();
    regs_rename_ckpt_if #(.NREGS(16), .DATA_W(16), .TAG_W(6),
        .NREAD(2), .NALLOC(4), .NWB(3)) if1 ();

    regs_rename_ckpt #(.NREGS(8), .DATA_W(16), .TAG_W(6), .NREAD(8),
        .NALLOC(4), .NWB(3), .ZERO_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));

    regs_rename_ckpt #(.NREGS(16), .DATA_W(16), .TAG_W(6), .NREAD(2),
        .NALLOC(4), .NWB(3), .ZERO_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct {
        int          inst;
        int          port;
        logic [RW-1:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string t, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    task automatic idle();
        if0.flush = 0; if0.alloc_en = '0; if0.wb_en = '0;
        if0.ckpt_save = 0; if0.ckpt_restore = 0;
        if1.flush = 0; if1.alloc_en = '0; if1.wb_en = '0;
        if1.ckpt_save = 0; if1.ckpt_restore = 0;
    endtask

    task automatic alloc(input int ln, input int a, input int t);
        if0.alloc_en[ln] = 1'b1;
        if0.alloc_addr[ln*3 +: 3] = 3'(a);
        if0.alloc_tag[ln*6 +: 6] = 6'(t);
    endtask

    task automatic wb(input int ln, input int a, input int d, input int t);
        if0.wb_en[ln] = 1'b1;
        if0.wb_addr[ln*3 +: 3] = 3'(a);
        if0.wb_data[ln*16 +: 16] = 16'(d);
        if0.wb_tag[ln*6 +: 6] = 6'(t);
    endtask

    task automatic rd(input int p, input int a, input int d, input int b,
                      input int t, input string nm);
        exp_t e;
        if0.raddr[p*3 +: 3] = 3'(a);
        e.inst = 0; e.port = p; e.name = nm;
        e.val = {16'(d), 1'(b), 6'(t)};
        sb.push_back(e);
    endtask

    task automatic rd1(input int p, input int a, input int d, input int b,
                       input int t, input string nm);
        exp_t e;
        if1.raddr[p*4 +: 4] = 4'(a);
        e.inst = 1; e.port = p; e.name = nm;
        e.val = {16'(d), 1'(b), 6'(t)};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0)
                chk(e.name, 64'(if0.rdata[e.port*RW +: RW]), 64'(e.val));
            else
                chk(e.name, 64'(if1.rdata[e.port*RW +: RW]), 64'(e.val));
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        if0.raddr = '0; if0.alloc_addr = '0; if0.alloc_tag = '0;
        if0.wb_addr = '0; if0.wb_data = '0; if0.wb_tag = '0;
        if1.raddr = '0; if1.alloc_addr = '0; if1.alloc_tag = '0;
        if1.wb_addr = '0; if1.wb_data = '0; if1.wb_tag = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", 64'(if0.rdata != '0), 64'd0);
        chk("rst_cv", 64'(if0.ckpt_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // same-cycle alloc lanes: youngest wins the tag
        alloc(0, 4, 9); alloc(2, 4, 12);
        rd(0, 4, 0, 1, 12, "alloc_youngest");
        tick();

        // wb clear suppressed by a same-cycle alloc
        wb(0, 4, 16'hBEEF, 12); alloc(1, 4, 20);
        rd(0, 4, 16'hBEEF, 1, 20, "wb_vs_alloc");
        tick();
        wb(1, 4, 16'h5555, 9);
        wb(0, 3, 16'h1111, 0); wb(2, 3, 16'h2222, 0);
        rd(0, 4, 16'h5555, 1, 20, "stale_wb");
        rd(1, 3, 16'h2222, 0, 0, "wb_hi_lane");
        tick();
        wb(2, 4, 16'h0A0A, 20);
        rd(0, 4, 16'h0A0A, 0, 20, "wb_clear");
        tick();

        // checkpoint recovery
        alloc(0, 1, 3); if0.ckpt_save = 1;
        rd(0, 1, 0, 1, 3, "save_alloc");
        tick();
        chk("cv_after_save", 64'(if0.ckpt_valid), 64'd1);
        alloc(3, 1, 7);
        rd(0, 1, 0, 1, 7, "alloc_after_save");
        tick();
        wb(0, 1, 16'h0033, 3);
        rd(0, 1, 16'h0033, 1, 7, "wb_old_tag");
        tick();
        if0.ckpt_restore = 1; alloc(1, 2, 30);
        rd(0, 1, 16'h0033, 0, 3, "restore_r1");
        rd(1, 2, 0, 0, 0, "restore_drops_alloc");
        tick();
        chk("cv_after_restore", 64'(if0.ckpt_valid), 64'd0);
        if0.ckpt_restore = 1; alloc(0, 6, 11);
        rd(0, 6, 0, 1, 11, "restore_noop");
        tick();

        // flush
        alloc(0, 7, 2);
        rd(0, 7, 0, 1, 2, "alloc_r7");
        tick();
        if0.flush = 1; alloc(0, 2, 1); wb(1, 5, 16'h1234, 0);
        rd(0, 2, 0, 0, 0, "flush_r2");
        rd(1, 7, 0, 0, 2, "flush_r7");
        rd(2, 5, 16'h1234, 0, 0, "flush_wb_r5");
        rd(3, 6, 0, 0, 11, "flush_r6");
        tick();

        // ZERO_REG instance
        if1.alloc_en[0] = 1; if1.alloc_addr[3:0] = 4'd0;
        if1.alloc_tag[5:0] = 6'd4;
        if1.alloc_en[1] = 1; if1.alloc_addr[7:4] = 4'd9;
        if1.alloc_tag[11:6] = 6'd4;
        if1.wb_en[0] = 1; if1.wb_addr[3:0] = 4'd0;
        if1.wb_data[15:0] = 16'hFFFF; if1.wb_tag[5:0] = 6'd4;
        rd1(0, 0, 0, 0, 0, "zero_r0");
        rd1(1, 9, 0, 1, 4, "z_alloc_r9");
        tick();
        if1.wb_en[2] = 1; if1.wb_addr[11:8] = 4'd9;
        if1.wb_data[47:32] = 16'h0099; if1.wb_tag[17:12] = 6'd4;
        rd1(1, 9, 16'h0099, 0, 4, "z_wb_r9");
        tick();

        // asynchronous reset mid-run
        alloc(0, 3, 5); if0.ckpt_save = 1;
        rd(0, 3, 16'h2222, 1, 5, "pre_reset");
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", 64'(if0.rdata != '0), 64'd0);
        chk("mid_rst_cv", 64'(if0.ckpt_valid), 64'd0);
        #1 rst_n = 1'b1;
        rd(0, 3, 0, 0, 0, "post_reset_r3");
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
